// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencer: owns the PC, fetches words over req/ack, selects the next PC from pcControl.
// Latency: 2 cycles per instruction with zero-wait memory (FETCH, EXEC); each memory wait cycle adds one.
// Backpressure: imem_req is held with a stable address until imem_ack; HALT stalls fetching until resume.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 21,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instruction,
    output logic                  instr_valid,
    input  logic [4:0]            pcControl,
    input  logic [20:0]           target,
    input  logic                  eq,
    input  logic                  lt,
    input  logic                  gt,
    input  logic                  zero,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted
);

    // NOP encoding (opcode 25) so the control unit sees a harmless word out of reset.
    localparam logic [31:0] NOP_INSTR = 32'h6400_0000;

    // Branch codes understood by the sequencer; everything above HALT falls through.
    localparam logic [4:0] PC_NONE  = 5'd0;
    localparam logic [4:0] PC_EQ    = 5'd1;
    localparam logic [4:0] PC_LT    = 5'd2;
    localparam logic [4:0] PC_GT    = 5'd3;
    localparam logic [4:0] PC_NE    = 5'd4;
    localparam logic [4:0] PC_LE    = 5'd5;
    localparam logic [4:0] PC_GE    = 5'd6;
    localparam logic [4:0] PC_NZ    = 5'd7;
    localparam logic [4:0] PC_Z     = 5'd8;
    localparam logic [4:0] PC_JMP   = 5'd9;
    localparam logic [4:0] PC_HALT  = 5'd10;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  load_instr;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] target_pc;
    logic                  br_taken;
    logic                  br_halt;

    // The 21-bit jump target is truncated or zero-extended to the PC width.
    generate
        if (ADDR_WIDTH <= 21) begin : g_tgt_trunc
            assign target_pc = target[ADDR_WIDTH-1:0];
        end else begin : g_tgt_ext
            assign target_pc = {{(ADDR_WIDTH-21){1'b0}}, target};
        end
    endgenerate

    // Sequential increment wraps naturally at 2^ADDR_WIDTH.
    assign pc_inc = pc + ADDR_WIDTH'(1);

    // Decode the control unit's PC code against the ALU status flags.
    always_comb begin
        br_taken = 1'b0;
        br_halt  = 1'b0;
        case (pcControl)
            PC_NONE: br_taken = 1'b0;
            PC_EQ:   br_taken = eq;
            PC_LT:   br_taken = lt;
            PC_GT:   br_taken = gt;
            PC_NE:   br_taken = ~eq;
            PC_LE:   br_taken = lt | eq;
            PC_GE:   br_taken = gt | eq;
            PC_NZ:   br_taken = ~zero;
            PC_Z:    br_taken = zero;
            PC_JMP:  br_taken = 1'b1;
            PC_HALT: br_halt  = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    // State register; reset parks the sequencer in FETCH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, instruction capture and PC selection.
    always_comb begin
        state_nxt  = state;
        load_instr = 1'b0;
        pc_load    = 1'b0;
        pc_nxt     = pc;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_nxt  = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_load = 1'b1;
                if (br_halt) begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_HALT;
                end else if (br_taken) begin
                    pc_nxt    = target_pc;
                    state_nxt = S_FETCH;
                end else begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                // resume only counts once HALT has actually been entered
                if (resume) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Program counter: loaded only on the edge leaving EXEC.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= pc_nxt;
        end
    end

    // Instruction register: captures read data on the ack edge, held otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction <= NOP_INSTR;
        end else if (load_instr) begin
            instruction <= imem_rdata;
        end
    end

    // Request is gated by reset so an in-flight fetch drops the moment reset rises.
    assign imem_req    = (state == S_FETCH) && !reset;
    assign imem_addr   = pc;
    assign instr_valid = (state == S_EXEC);
    assign halted      = (state == S_HALT);

endmodule
